wb_reg_file: RTL and testbench

//   Writeback-stage consumer of the MEM/WB pipeline register, together with the architectural register file.

---
 rtl/wb_reg_file_pkg.sv | 16 +
 rtl/wb_reg_file_if.sv | 33 +++
 rtl/wb_reg_file_reg_array.sv | 36 +++
 rtl/wb_reg_file.sv | 91 +++++++++
 tb/tb_wb_reg_file.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/wb_reg_file_pkg.sv
// Shared writeback definitions: MemToReg source encodings and the hardwired zero register index.
// No logic, so no latency.
// No handshake, so no backpressure.
package wb_reg_file_pkg;

  // Writeback source select, same encoding as the controller drives on MemToReg
  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'b00,
    WB_SRC_MEM  = 2'b01,
    WB_SRC_PC   = 2'b10,
    WB_SRC_RSVD = 2'b11
  } wb_src_e;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_reg_file_if.sv
// Bus between the MEM/WB register plus ID read ports and the writeback/register-file block.
// Carries signals only, so no latency.
// No backpressure: WB commits unconditionally and reads are combinational.
interface wb_reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWr;
  logic [1:0]        MemToReg;
  logic [DATA_W-1:0] ALUResult;
  logic [DATA_W-1:0] ReadData;
  logic [31:0]       RegDst;
  logic [DATA_W-1:0] NextPC;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [DATA_W-1:0] WBData;
  logic              WBValid;
  logic [31:0]       WrCount;

  // Pipeline side: drives the MEM/WB fields and read indices, consumes results
  modport master (
    output RegWr, MemToReg, ALUResult, ReadData, RegDst, NextPC, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, WBData, WBValid, WrCount
  );

  // Register-file side
  modport slave (
    input  RegWr, MemToReg, ALUResult, ReadData, RegDst, NextPC, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, WBData, WBValid, WrCount
  );
endinterface

// File: rtl/wb_reg_file_reg_array.sv
// Register storage with one synchronous write port and two asynchronous read ports.
// Write lands on the clock edge; reads are combinational (0 cycles).
// No backpressure; an asserted write enable always commits unless reset is low.
module wb_reg_file_reg_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [NREGS];

  // Storage: whole array clears asynchronously; reset beats a coincident write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/wb_reg_file.sv
// Writeback stage: selects WB value, commits to the register file, serves two bypassed ID read ports.
// WBData/WBValid/read data are combinational (0 cycles); array value visible the cycle after the write edge.
// No backpressure: every effective write commits; writes to register 0 are dropped and not counted.
module wb_reg_file
  import wb_reg_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          reset,
  wb_reg_file_if.slave  bus
);
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_valid;
  logic [DATA_W-1:0] w_arr_rd1;
  logic [DATA_W-1:0] w_arr_rd2;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [31:0]       r_wr_count;
  logic              w_unused_regdst_hi;

  // Only the low index bits address the array; upper destination bits are don't-care
  assign w_waddr            = bus.RegDst[ADDR_W-1:0];
  assign w_unused_regdst_hi = ^bus.RegDst[31:ADDR_W];

  // Writeback source mux; the reserved encoding (and anything unknown) falls back to the ALU result
  always_comb begin
    w_wb_data = bus.ALUResult;
    case (wb_src_e'(bus.MemToReg))
      WB_SRC_MEM: w_wb_data = bus.ReadData;
      WB_SRC_PC:  w_wb_data = bus.NextPC;
      default:    w_wb_data = bus.ALUResult;
    endcase
  end

  assign w_wb_valid = bus.RegWr && (w_waddr != ADDR_W'(REG_ZERO));

  wb_reg_file_reg_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_reg_array (
    .clk      (clk),
    .reset    (reset),
    .i_we     (w_wb_valid),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wb_data),
    .i_raddr1 (bus.ReadReg1),
    .i_raddr2 (bus.ReadReg2),
    .o_rdata1 (w_arr_rd1),
    .o_rdata2 (w_arr_rd2)
  );

  // Read port 1: zero register and reset force 0, then write-first bypass, then stored value
  always_comb begin
    w_rd1 = w_arr_rd1;
    if (!reset || bus.ReadReg1 == ADDR_W'(REG_ZERO)) begin
      w_rd1 = '0;
    end else if (BYPASS != 0 && w_wb_valid && bus.ReadReg1 == w_waddr) begin
      w_rd1 = w_wb_data;
    end
  end

  // Read port 2: same priority as port 1; both may bypass in the same cycle
  always_comb begin
    w_rd2 = w_arr_rd2;
    if (!reset || bus.ReadReg2 == ADDR_W'(REG_ZERO)) begin
      w_rd2 = '0;
    end else if (BYPASS != 0 && w_wb_valid && bus.ReadReg2 == w_waddr) begin
      w_rd2 = w_wb_data;
    end
  end

  // Committed-write counter, wraps naturally at 2**32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_count <= '0;
    end else if (w_wb_valid) begin
      r_wr_count <= r_wr_count + 32'd1;
    end
  end

  assign bus.ReadData1 = w_rd1;
  assign bus.ReadData2 = w_rd2;
  assign bus.WBData    = w_wb_data;
  assign bus.WBValid   = w_wb_valid;
  assign bus.WrCount   = r_wr_count;

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed bench for wb_reg_file: one bypassing instance and one non-bypassing instance on shared stimulus.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
// Each comparison is an immediate assertion that counts and reports a miscompare.
module tb_wb_reg_file;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWr = 1'b0;
  logic [1:0]  MemToReg = 2'b00;
  logic [31:0] ALUResult = '0;
  logic [31:0] ReadData = '0;
  logic [31:0] RegDst = '0;
  logic [31:0] NextPC = '0;
  logic [4:0]  ReadReg1 = '0;
  logic [4:0]  ReadReg2 = '0;

  int vectors = 0;
  int errors  = 0;

  wb_reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
  wb_reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();

  assign bus_a.RegWr = RegWr;   assign bus_b.RegWr = RegWr;
  assign bus_a.MemToReg = MemToReg; assign bus_b.MemToReg = MemToReg;
  assign bus_a.ALUResult = ALUResult; assign bus_b.ALUResult = ALUResult;
  assign bus_a.ReadData = ReadData; assign bus_b.ReadData = ReadData;
  assign bus_a.RegDst = RegDst; assign bus_b.RegDst = RegDst;
  assign bus_a.NextPC = NextPC; assign bus_b.NextPC = NextPC;
  assign bus_a.ReadReg1 = ReadReg1; assign bus_b.ReadReg1 = ReadReg1;
  assign bus_a.ReadReg2 = ReadReg2; assign bus_b.ReadReg2 = ReadReg2;

  wb_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  wb_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] src, input logic [31:0] dst, input logic [31:0] alu,
                    input logic [31:0] mem, input logic [31:0] pc);
    RegWr = 1'b1; MemToReg = src; RegDst = dst;
    ALUResult = alu; ReadData = mem; NextPC = pc;
    step();
    RegWr = 1'b0;
  endtask

  initial begin
    // Power-on reset, then one write so the mid-cycle pulse has something to clear
    step(); step();
    reset = 1'b1;
    step();
    wr(2'b00, 32'd4, 32'h55, 32'h0, 32'h0);
    ReadReg1 = 5'd4; #1;
    check("pre_pulse_r4", bus_a.ReadData1, 32'h55);
    check("pre_pulse_cnt", bus_a.WrCount, 32'd1);

    // 1. Mid-cycle reset pulse clears everything immediately
    #1 reset = 1'b0;
    #1;
    check("rst_rd1", bus_a.ReadData1, 32'h0);
    check("rst_cnt", bus_a.WrCount, 32'h0);
    #1 reset = 1'b1;
    #1;
    check("rst_after_r4", bus_a.ReadData1, 32'h0);
    step();

    // 2. One write from each source
    RegWr = 1'b1; MemToReg = 2'b00; RegDst = 32'd8; ALUResult = 32'h1234;
    ReadData = 32'h0; NextPC = 32'h0; #1;
    check("wbdata_alu", bus_a.WBData, 32'h1234);
    check("wbvalid_r8", {31'b0, bus_a.WBValid}, 32'h1);
    step(); RegWr = 1'b0;
    ReadReg1 = 5'd8; #1;
    check("rd_r8", bus_a.ReadData1, 32'h1234);
    wr(2'b01, 32'd9, 32'h0, 32'hDEADBEEF, 32'h0);
    ReadReg1 = 5'd9; #1;
    check("rd_r9", bus_a.ReadData1, 32'hDEADBEEF);
    wr(2'b10, 32'd31, 32'h0, 32'h0, 32'h00400010);
    ReadReg1 = 5'd31; #1;
    check("rd_r31", bus_a.ReadData1, 32'h00400010);
    check("cnt_3", bus_a.WrCount, 32'd3);

    // 3. Writes to $zero are dropped
    RegWr = 1'b1; MemToReg = 2'b00; RegDst = 32'd0; ALUResult = 32'hFFFFFFFF;
    ReadReg1 = 5'd0; #1;
    check("zero_wbvalid", {31'b0, bus_a.WBValid}, 32'h0);
    check("zero_rd_same", bus_a.ReadData1, 32'h0);
    step(); RegWr = 1'b0; #1;
    check("zero_rd_after", bus_a.ReadData1, 32'h0);
    check("zero_cnt", bus_a.WrCount, 32'd3);

    // 4. Same-cycle bypass on both ports, and its absence when disabled
    wr(2'b00, 32'd5, 32'h11, 32'h0, 32'h0);
    RegWr = 1'b1; RegDst = 32'd5; ALUResult = 32'h22;
    ReadReg1 = 5'd5; ReadReg2 = 5'd5; #1;
    check("byp_a_rd1", bus_a.ReadData1, 32'h22);
    check("byp_a_rd2", bus_a.ReadData2, 32'h22);
    check("nobyp_b_rd1", bus_b.ReadData1, 32'h11);
    check("nobyp_b_rd2", bus_b.ReadData2, 32'h11);
    step(); RegWr = 1'b0; #1;
    check("byp_after_a", bus_a.ReadData2, 32'h22);
    check("byp_after_b", bus_b.ReadData1, 32'h22);
    check("cnt_5", bus_a.WrCount, 32'd5);

    // 5. Upper RegDst bits ignored; reserved select takes the ALU result
    RegWr = 1'b1; MemToReg = 2'b11; RegDst = 32'hFFFFFFE7;
    ALUResult = 32'hCAFE; ReadData = 32'hBAD; NextPC = 32'h4; #1;
    check("rsvd_wbdata", bus_a.WBData, 32'hCAFE);
    step(); RegWr = 1'b0;
    ReadReg1 = 5'd7; ReadReg2 = 5'd8; #1;
    check("rd_r7", bus_a.ReadData1, 32'hCAFE);
    check("r8_intact", bus_a.ReadData2, 32'h1234);
    check("cnt_6", bus_a.WrCount, 32'd6);

    // Unknown select with RegWr low leaves state alone
    MemToReg = 2'bxx; RegDst = 32'd7; ALUResult = 32'h0BAD;
    step(); MemToReg = 2'b00; #1;
    check("x_sel_r7", bus_a.ReadData1, 32'hCAFE);
    check("x_sel_cnt", bus_a.WrCount, 32'd6);

    // 6. Reset coincident with a write: reset wins
    RegWr = 1'b1; RegDst = 32'd3; ALUResult = 32'h33;
    ReadReg1 = 5'd3; ReadReg2 = 5'd8;
    reset = 1'b0; #1;
    check("rst_wr_rd1", bus_a.ReadData1, 32'h0);
    check("rst_wr_rd2", bus_a.ReadData2, 32'h0);
    step();
    reset = 1'b1; RegWr = 1'b0; #1;
    check("rst_wr_r3", bus_a.ReadData1, 32'h0);
    check("rst_wr_r8", bus_a.ReadData2, 32'h0);
    check("rst_wr_cnt", bus_a.WrCount, 32'h0);

    // Writes resume normally after release
    wr(2'b00, 32'd3, 32'h77, 32'h0, 32'h0);
    #1;
    check("post_rst_r3", bus_a.ReadData1, 32'h77);
    check("post_rst_cnt", bus_a.WrCount, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
